mc_controller: RTL
==================

Name: mc_controller

Overview:
- Control unit for the multicycle ARM core. Sits directly upstream of the datapath and drives every datapath select and enable.
- Consumes Instr and ALUFlags from the datapath.
- Contains the main FSM, the instruction decoder, the flags register and the condition check.
- Supports the data-processing, LDR/STR, B and MUL/UMULL/SMULL instructions.

Parameters:
- None. The instruction subset is fixed.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Instr  in  32  instruction register output from the datapath.
- ALUFlags  in  4  {N,Z,C,V} from the datapath ALU, combinational.
- PCWrite  out  1  PC register enable.
- MemWrite  out  1  memory write strobe.
- RegWrite  out  1  register file write enable.
- IRWrite  out  1  instruction register enable.
- AdrSrc  out  1  0 = PC, 1 = Result.
- RegSrc  out  2  bit0 = RA1 is R15; bit1 = RA2 is Instr[15:12].
- ALUSrcA  out  2  00 = A, 01 = PC.
- ALUSrcB  out  2  00 = WriteData, 01 = ExtImm, 10 = constant 4.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ImmSrc  out  2  equals Instr[27:26].
- ALUControl  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 MUL, 0101 UMULL, 0110 SMULL.
- is_mul  out  1  high when Instr is a multiply.

Behaviour:
- Reset (reset low, async):
  - State forced to FETCH; Flags = 0000; CondExR = 0.
  - While reset is low, PCWrite, MemWrite, RegWrite and IRWrite are forced to 0.
  - The first cycle after release performs FETCH.
- Output timing: all outputs are combinational from the state and Instr; no output registers.
- Decode, by Op = Instr[27:26]:
  - 00 data-processing: cmd Instr[24:21] maps 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, no register write). S = Instr[20]. I = Instr[25].
  - is_mul = (Instr[27:24] == 0000) & (Instr[7:4] == 1001). Its type comes from Instr[23:21]: 000 MUL, 100 UMULL, 110 SMULL. Any other code is unsupported.
  - 01 memory: L = Instr[20].
  - 10 branch.
  - 11, and any unsupported cmd, goes to UNKNOWN.
- RegSrc, from Instr only:
  - RegSrc[0] = (Op == 10).
  - RegSrc[1] = (Op == 01) & ~L.
- Condition check:
  - CondEx is evaluated from the Flags register against Instr[31:28] using the standard ARM EQ..LE semantics.
  - 1110 (AL) = 1; 1111 = 0.
- CondExR is latched at the end of DECODE.
- States and outputs; unlisted outputs are 0 and ALUControl defaults to ADD:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, PCWrite=1. Next state: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Next state by type:
    - memory: MEMADR
    - data-processing with I=0, or multiply: EXECUTER
    - data-processing with I=1: EXECUTEI
    - branch: BRANCH
    - anything else: UNKNOWN
  - MEMADR: ALUSrcA=00, ALUSrcB=01. Next: MEMREAD if L, else MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=CondExR. Next: FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=CondExR. Next: FETCH.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUControl=decoded. Next: ALUWB.
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUControl=decoded. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=CondExR & ~CMP. If Instr[15:12] == 1111 and not a multiply, PCWrite=CondExR. Next: FETCH.
  - BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, PCWrite=CondExR. Next: FETCH.
  - UNKNOWN: no enables asserted. Next: FETCH.
- Flags register:
  - Loaded with ALUFlags at the end of EXECUTER/EXECUTEI when (S | CMP) & CondExR.
  - Multiplies never update Flags.
  - The updated flags are first visible to the next instruction's DECODE.
- Latency in cycles: data-processing 4, multiply 4, LDR 5, STR 4, B 3, unknown 3.
- Boundary conditions:
  - Reset asserted mid-instruction aborts it; no enable is asserted after the reset edge.
  - A failed condition still walks the full state sequence, with all writes suppressed except FETCH's PCWrite.

Test Plan:
- Hold reset low 3 cycles, then release -> write enables stay 0 during reset; first cycle is FETCH with IRWrite=1, PCWrite=1, ALUSrcB=10.
- Instr=0xE0821003 (ADD R1,R2,R3) -> states FETCH, DECODE, EXECUTER, ALUWB; RegWrite=1 only in ALUWB; ALUControl=0000 in EXECUTER.
- Instr=0xE5921004 (LDR) -> 5 cycles; MEMREAD has AdrSrc=1; MEMWB has ResultSrc=01 and RegWrite=1. Instr=0xE5821004 (STR) -> MemWrite=1 in cycle 4; RegSrc=10.
- Instr=0xE0500000 (SUBS) with ALUFlags=0100 in EXECUTER, then 0x0A000002 (BEQ) -> BRANCH asserts PCWrite=1. Repeat with ALUFlags=0000 -> PCWrite=0 in BRANCH.
- Instr=0xE0854392 (UMULL) -> is_mul=1, ALUControl=0101, RegWrite=1 in ALUWB, Flags unchanged.
- Instr with Op=11 -> FETCH, DECODE, UNKNOWN, FETCH; no RegWrite, MemWrite or extra PCWrite.

Source files
------------

// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle ARM controller and its datapath.
//   Instr, ALUFlags : datapath -> controller (instruction register, ALU flags {N,Z,C,V})
//   PCWrite .. is_mul : controller -> datapath (selects and enables)
// master = controller side, slave = datapath side.
interface mc_controller_if;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic        IRWrite;
    logic        AdrSrc;
    logic [1:0]  RegSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [3:0]  ALUControl;
    logic        is_mul;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, is_mul
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, is_mul
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: main FSM, instruction decoder, flags register
// and condition check. Drives every datapath select/enable combinationally
// from the current state and Instr.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : mc_controller_if.master (Instr/ALUFlags in, controls out)
//
// state      | meaning
// -----------+------------------------------------------------
// FETCH      | read instruction at PC, IR <= mem, PC <= PC+4
// DECODE     | read registers, latch condition result
// MEMADR     | compute load/store address
// MEMREAD    | read data memory
// MEMWB      | write loaded data to register file
// MEMWRITE   | write data memory
// EXECUTER   | ALU / multiply with register operand
// EXECUTEI   | ALU with immediate operand
// ALUWB      | write ALU result (PC if Rd = R15)
// BRANCH     | PC <= PC+8+offset
// UNKNOWN    | unsupported instruction, no side effects
module mc_controller (
    input  logic             clk,
    input  logic             reset,
    mc_controller_if.master  bus
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_UNKNOWN
    } state_t;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_ORR   = 4'b0011;
    localparam logic [3:0] ALU_MUL   = 4'b0100;
    localparam logic [3:0] ALU_UMULL = 4'b0101;
    localparam logic [3:0] ALU_SMULL = 4'b0110;

    state_t      state, next_state;
    logic [3:0]  flags;
    logic        cond_ex, cond_ex_r;

    logic [1:0]  op;
    logic        i_bit, s_bit, l_bit, mul_hit, is_cmp, dp_ok, rd_pc;
    logic [3:0]  alu_dec;

    logic        pc_w, mem_w, reg_w, ir_w, adr_src;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [3:0]  alu_control;

    logic        unused_instr;

    assign op      = bus.Instr[27:26];
    assign i_bit   = bus.Instr[25];
    assign s_bit   = bus.Instr[20];
    assign l_bit   = bus.Instr[20];
    assign mul_hit = (bus.Instr[27:24] == 4'b0000) && (bus.Instr[7:4] == 4'b1001);
    assign is_cmp  = !mul_hit && (op == 2'b00) && (bus.Instr[24:21] == 4'b1010);
    assign rd_pc   = (bus.Instr[15:12] == 4'b1111);
    assign unused_instr = ^{bus.Instr[19:16], bus.Instr[11:8], bus.Instr[3:0]};

    // Multiply encodings share Op=00 with data-processing; multiply wins.
    always_comb begin
        dp_ok   = 1'b0;
        alu_dec = ALU_ADD;
        if (mul_hit) begin
            case (bus.Instr[23:21])
                3'b000:  begin dp_ok = 1'b1; alu_dec = ALU_MUL;   end
                3'b100:  begin dp_ok = 1'b1; alu_dec = ALU_UMULL; end
                3'b110:  begin dp_ok = 1'b1; alu_dec = ALU_SMULL; end
                default: begin dp_ok = 1'b0; alu_dec = ALU_ADD;   end
            endcase
        end else begin
            case (bus.Instr[24:21])
                4'b0100: begin dp_ok = 1'b1; alu_dec = ALU_ADD; end
                4'b0010: begin dp_ok = 1'b1; alu_dec = ALU_SUB; end
                4'b0000: begin dp_ok = 1'b1; alu_dec = ALU_AND; end
                4'b1100: begin dp_ok = 1'b1; alu_dec = ALU_ORR; end
                4'b1010: begin dp_ok = 1'b1; alu_dec = ALU_SUB; end
                default: begin dp_ok = 1'b0; alu_dec = ALU_ADD; end
            endcase
        end
    end

    // flags = {N,Z,C,V}
    always_comb begin
        cond_ex = 1'b0;
        case (bus.Instr[31:28])
            4'b0000: cond_ex = flags[2];
            4'b0001: cond_ex = !flags[2];
            4'b0010: cond_ex = flags[1];
            4'b0011: cond_ex = !flags[1];
            4'b0100: cond_ex = flags[3];
            4'b0101: cond_ex = !flags[3];
            4'b0110: cond_ex = flags[0];
            4'b0111: cond_ex = !flags[0];
            4'b1000: cond_ex = flags[1] && !flags[2];
            4'b1001: cond_ex = !flags[1] || flags[2];
            4'b1010: cond_ex = (flags[3] == flags[0]);
            4'b1011: cond_ex = (flags[3] != flags[0]);
            4'b1100: cond_ex = !flags[2] && (flags[3] == flags[0]);
            4'b1101: cond_ex = flags[2] || (flags[3] != flags[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_FETCH;
            flags     <= 4'b0000;
            cond_ex_r <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_DECODE)
                cond_ex_r <= cond_ex;
            if ((state == S_EXECUTER || state == S_EXECUTEI) &&
                (s_bit || is_cmp) && cond_ex_r && !mul_hit)
                flags <= bus.ALUFlags;
        end
    end

    always_comb begin
        next_state  = S_FETCH;
        pc_w        = 1'b0;
        mem_w       = 1'b0;
        reg_w       = 1'b0;
        ir_w        = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_control = ALU_ADD;
        case (state)
            S_FETCH: begin
                ir_w = 1'b1; pc_w = 1'b1;
                alu_src_a = 2'b01; alu_src_b = 2'b10; result_src = 2'b10;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01; alu_src_b = 2'b10; result_src = 2'b10;
                if (op == 2'b01)
                    next_state = S_MEMADR;
                else if (op == 2'b00 && dp_ok)
                    next_state = (mul_hit || !i_bit) ? S_EXECUTER : S_EXECUTEI;
                else if (op == 2'b10)
                    next_state = S_BRANCH;
                else
                    next_state = S_UNKNOWN;
            end
            S_MEMADR: begin
                alu_src_b = 2'b01;
                next_state = l_bit ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01; reg_w = cond_ex_r;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1; mem_w = cond_ex_r;
            end
            S_EXECUTER: begin
                alu_control = alu_dec;
                next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_b = 2'b01; alu_control = alu_dec;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w = cond_ex_r && !is_cmp;
                pc_w  = cond_ex_r && rd_pc && !mul_hit;
            end
            S_BRANCH: begin
                alu_src_b = 2'b01; result_src = 2'b10; pc_w = cond_ex_r;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Enables are gated by reset so nothing fires while reset is held,
    // even though the state register already reads FETCH.
    assign bus.PCWrite    = pc_w  && reset;
    assign bus.MemWrite   = mem_w && reset;
    assign bus.RegWrite   = reg_w && reset;
    assign bus.IRWrite    = ir_w  && reset;
    assign bus.AdrSrc     = adr_src;
    assign bus.RegSrc     = {(op == 2'b01) && !l_bit, (op == 2'b10)};
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ResultSrc  = result_src;
    assign bus.ImmSrc     = op;
    assign bus.ALUControl = alu_control;
    assign bus.is_mul     = mul_hit;
endmodule
